// File: rtl/vai_ctl_csr_arb.sv
// vai_ctl_csr_arb: control/status registers and MMIO response merger for the VAI mux.
// Decodes host MMIO, owns the control window, forwards other requests to the
// sub-AFU mux, and merges control read data with buffered sub-AFU responses.
// Optional feature macro: VAI_CTL_SCRATCH_EN (word 7 becomes a 64-bit scratch register).
module vai_ctl_csr_arb #(
  parameter int unsigned NUM_SUB_AFUS   = 8,
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned CTL_SPACE_W    = 10,
  parameter int unsigned RESET_HOLD     = 16,
  parameter int unsigned RSP_FIFO_DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       mmio_wr_valid_i,
  input  logic                       mmio_rd_valid_i,
  input  logic [ADDR_W-1:0]          mmio_addr_i,
  input  logic [8:0]                 mmio_tid_i,
  input  logic [63:0]                mmio_wdata_i,
  output logic                       fwd_wr_valid_o,
  output logic                       fwd_rd_valid_o,
  output logic [ADDR_W-1:0]          fwd_addr_o,
  output logic [8:0]                 fwd_tid_o,
  output logic [63:0]                fwd_wdata_o,
  input  logic                       sub_rsp_valid_i,
  input  logic [8:0]                 sub_rsp_tid_i,
  input  logic [63:0]                sub_rsp_data_i,
  output logic                       sub_rsp_almfull_o,
  output logic                       rsp_valid_o,
  output logic [8:0]                 rsp_tid_o,
  output logic [63:0]                rsp_data_o,
  output logic [64*NUM_SUB_AFUS-1:0] offset_flat_o,
  output logic [NUM_SUB_AFUS-1:0]    sub_afu_en_o,
  output logic [NUM_SUB_AFUS-1:0]    sub_afu_reset_o
);

  localparam int unsigned N    = NUM_SUB_AFUS;
  localparam int unsigned CW   = $clog2(RESET_HOLD + 1);
  localparam int unsigned PW   = $clog2(RSP_FIFO_DEPTH);
  localparam int unsigned RW   = 9 + 64;
  localparam logic [63:0] DFH   = 64'h1000_0100_0000_0000;
  localparam logic [63:0] ID_LO = 64'ha0a0_13a4_2113_9e6a;
  localparam logic [63:0] ID_HI = 64'hd1d3_83aa_ca4c_4c60;

  // Address decode of the incoming request
  logic       in_ctl_c, mapped_c, ctl_wr_c;
  logic [6:0] word_c;
  assign in_ctl_c = (mmio_addr_i >> CTL_SPACE_W) == '0;
  assign mapped_c = in_ctl_c && ((mmio_addr_i >> 8) == '0);
  assign word_c   = mmio_addr_i[7:1];
  assign ctl_wr_c = mmio_wr_valid_i && mapped_c;

  logic              fwd_wr_valid_q, fwd_rd_valid_q;
  logic [ADDR_W-1:0] fwd_addr_q;
  logic [8:0]        fwd_tid_q;
  logic [63:0]       fwd_wdata_q;

  // Register requests that fall outside the control window
  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_wr_valid_q <= 1'b0;
      fwd_rd_valid_q <= 1'b0;
      fwd_addr_q     <= '0;
      fwd_tid_q      <= '0;
      fwd_wdata_q    <= '0;
    end else begin
      fwd_wr_valid_q <= mmio_wr_valid_i && !in_ctl_c;
      fwd_rd_valid_q <= mmio_rd_valid_i && !in_ctl_c;
      if ((mmio_wr_valid_i || mmio_rd_valid_i) && !in_ctl_c) begin
        fwd_addr_q  <= mmio_addr_i;
        fwd_tid_q   <= mmio_tid_i;
        fwd_wdata_q <= mmio_wdata_i;
      end
    end
  end

  logic       ctl_rd_q, ctl_map_q;
  logic [6:0] ctl_word_q;
  logic [8:0] ctl_tid_q;

  // First stage of a control read; data is selected from registers one cycle later
  always_ff @(posedge clk) begin
    if (reset) begin
      ctl_rd_q   <= 1'b0;
      ctl_map_q  <= 1'b0;
      ctl_word_q <= '0;
      ctl_tid_q  <= '0;
    end else begin
      ctl_rd_q   <= mmio_rd_valid_i && in_ctl_c;
      ctl_map_q  <= mapped_c;
      ctl_word_q <= word_c;
      ctl_tid_q  <= mmio_tid_i;
    end
  end

  logic [N-1:0] en_q;
  logic [63:0]  offset_q [N];
`ifdef VAI_CTL_SCRATCH_EN
  logic [63:0]  scratch_q;
`endif

  // Writable control registers
  always_ff @(posedge clk) begin
    if (reset) begin
      en_q <= '1;
      for (int i = 0; i < int'(N); i++) offset_q[i] <= '0;
`ifdef VAI_CTL_SCRATCH_EN
      scratch_q <= '0;
`endif
    end else if (ctl_wr_c) begin
      if (word_c == 7'd5) en_q <= mmio_wdata_i[N-1:0];
      for (int i = 0; i < int'(N); i++)
        if (word_c == 7'(8 + i)) offset_q[i] <= mmio_wdata_i;
`ifdef VAI_CTL_SCRATCH_EN
      if (word_c == 7'd7) scratch_q <= mmio_wdata_i;
`endif
    end
  end

  logic [CW-1:0] hold_q [N];
  logic [CW-1:0] hold_d [N];
  logic [N-1:0]  rst_q;

  // Per-sub-AFU reset hold counters; a write-1 (re)loads the full hold time
  always_comb begin
    for (int i = 0; i < int'(N); i++) begin
      hold_d[i] = hold_q[i];
      if (ctl_wr_c && word_c == 7'd3 && mmio_wdata_i[i]) hold_d[i] = CW'(RESET_HOLD);
      else if (hold_q[i] != '0)                           hold_d[i] = hold_q[i] - CW'(1);
    end
  end

  // Counter state and the registered pulse outputs
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(N); i++) begin
      if (reset) begin
        hold_q[i] <= '0;
        rst_q[i]  <= 1'b0;
      end else begin
        hold_q[i] <= hold_d[i];
        rst_q[i]  <= hold_d[i] != '0;
      end
    end
  end

  logic [63:0] ctl_rdata_c;
  logic        ovf_q, ovf_d;

  // Read data select for the control read in its second stage
  always_comb begin
    ctl_rdata_c = '1;
    if (ctl_map_q) begin
      case (ctl_word_q)
        7'd0: ctl_rdata_c = DFH;
        7'd1: ctl_rdata_c = ID_LO;
        7'd2: ctl_rdata_c = ID_HI;
        7'd3: ctl_rdata_c = 64'(rst_q);
        7'd4: ctl_rdata_c = 64'(N);
        7'd5: ctl_rdata_c = 64'(en_q);
        7'd6: ctl_rdata_c = {63'd0, ovf_q};
        7'd7: begin
`ifdef VAI_CTL_SCRATCH_EN
          ctl_rdata_c = scratch_q;
`else
          ctl_rdata_c = '1;
`endif
        end
        default: begin
          for (int i = 0; i < int'(N); i++)
            if (ctl_word_q == 7'(8 + i)) ctl_rdata_c = offset_q[i];
        end
      endcase
    end
  end

  logic [RW-1:0] fifo_mem [RSP_FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   fcnt_q, fcnt_d;
  logic          push_c, pop_c, almfull_q;
  logic          rsp_valid_q, rsp_valid_d;
  logic [8:0]    rsp_tid_q, rsp_tid_d;
  logic [63:0]   rsp_data_q, rsp_data_d;

  // Response merge: control data wins, otherwise drain one FIFO entry
  always_comb begin
    rsp_valid_d = 1'b0;
    rsp_tid_d   = rsp_tid_q;
    rsp_data_d  = rsp_data_q;
    pop_c       = 1'b0;
    if (ctl_rd_q) begin
      rsp_valid_d = 1'b1;
      rsp_tid_d   = ctl_tid_q;
      rsp_data_d  = ctl_rdata_c;
    end else if (fcnt_q != '0) begin
      pop_c       = 1'b1;
      rsp_valid_d = 1'b1;
      {rsp_tid_d, rsp_data_d} = fifo_mem[rd_ptr_q];
    end
    push_c = sub_rsp_valid_i && ((fcnt_q != (PW+1)'(RSP_FIFO_DEPTH)) || pop_c);
    fcnt_d = fcnt_q + (PW+1)'(push_c) - (PW+1)'(pop_c);
    ovf_d  = ovf_q;
    if (ctl_rd_q && ctl_map_q && ctl_word_q == 7'd6) ovf_d = 1'b0;
    if (sub_rsp_valid_i && !push_c)                    ovf_d = 1'b1;
  end

  // FIFO storage (no reset needed on the data array)
  always_ff @(posedge clk) begin
    if (push_c) fifo_mem[wr_ptr_q] <= {sub_rsp_tid_i, sub_rsp_data_i};
  end

  // FIFO pointers, status and merged response registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fcnt_q      <= '0;
      almfull_q   <= 1'b0;
      ovf_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_tid_q   <= '0;
      rsp_data_q  <= '0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + PW'(1);
      fcnt_q      <= fcnt_d;
      almfull_q   <= fcnt_d >= (PW+1)'(RSP_FIFO_DEPTH - 2);
      ovf_q       <= ovf_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_tid_q   <= rsp_tid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // Flatten offsets onto the output bus
  always_comb begin
    offset_flat_o = '0;
    for (int i = 0; i < int'(N); i++) offset_flat_o[64*i +: 64] = offset_q[i];
  end

  assign fwd_wr_valid_o    = fwd_wr_valid_q;
  assign fwd_rd_valid_o    = fwd_rd_valid_q;
  assign fwd_addr_o        = fwd_addr_q;
  assign fwd_tid_o         = fwd_tid_q;
  assign fwd_wdata_o       = fwd_wdata_q;
  assign sub_rsp_almfull_o = almfull_q;
  assign rsp_valid_o       = rsp_valid_q;
  assign rsp_tid_o         = rsp_tid_q;
  assign rsp_data_o        = rsp_data_q;
  assign sub_afu_en_o      = en_q;
  assign sub_afu_reset_o   = rst_q;

endmodule

// File: tb/tb_vai_ctl_csr_arb.sv
// Bench for vai_ctl_csr_arb: directed steps with a response scoreboard.
module tb_vai_ctl_csr_arb;
  localparam int unsigned N = 8;
  localparam logic [63:0] DFH   = 64'h1000_0100_0000_0000;
  localparam logic [63:0] ID_LO = 64'ha0a013a421139e6a;
  localparam logic [63:0] ID_HI = 64'hd1d383aaca4c4c60;
  localparam logic [63:0] ONES  = '1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mmio_wr_valid_i = 1'b0, mmio_rd_valid_i = 1'b0;
  logic [15:0] mmio_addr_i = '0;
  logic [8:0]  mmio_tid_i = '0;
  logic [63:0] mmio_wdata_i = '0;
  logic fwd_wr_valid_o, fwd_rd_valid_o;
  logic [15:0] fwd_addr_o;
  logic [8:0]  fwd_tid_o;
  logic [63:0] fwd_wdata_o;
  logic sub_rsp_valid_i = 1'b0;
  logic [8:0]  sub_rsp_tid_i = '0;
  logic [63:0] sub_rsp_data_i = '0;
  logic sub_rsp_almfull_o, rsp_valid_o;
  logic [8:0]  rsp_tid_o;
  logic [63:0] rsp_data_o;
  logic [64*N-1:0] offset_flat_o;
  logic [N-1:0] sub_afu_en_o, sub_afu_reset_o;

  int checks = 0;
  int errors = 0;

  typedef struct packed { logic [8:0] tid; logic [63:0] data; } exp_t;
  exp_t sb[$];
  exp_t sub_q[$];

  vai_ctl_csr_arb dut (
    .clk(clk), .reset(reset),
    .mmio_wr_valid_i(mmio_wr_valid_i), .mmio_rd_valid_i(mmio_rd_valid_i),
    .mmio_addr_i(mmio_addr_i), .mmio_tid_i(mmio_tid_i), .mmio_wdata_i(mmio_wdata_i),
    .fwd_wr_valid_o(fwd_wr_valid_o), .fwd_rd_valid_o(fwd_rd_valid_o),
    .fwd_addr_o(fwd_addr_o), .fwd_tid_o(fwd_tid_o), .fwd_wdata_o(fwd_wdata_o),
    .sub_rsp_valid_i(sub_rsp_valid_i), .sub_rsp_tid_i(sub_rsp_tid_i),
    .sub_rsp_data_i(sub_rsp_data_i), .sub_rsp_almfull_o(sub_rsp_almfull_o),
    .rsp_valid_o(rsp_valid_o), .rsp_tid_o(rsp_tid_o), .rsp_data_o(rsp_data_o),
    .offset_flat_o(offset_flat_o), .sub_afu_en_o(sub_afu_en_o),
    .sub_afu_reset_o(sub_afu_reset_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] e);
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, e);
    end
  endtask

  // Every merged response is compared against the head of the scoreboard
  always @(negedge clk) begin
    if (rsp_valid_o === 1'b1) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL rsp_unexpected observed tid=%0h data=%0h expected=none", rsp_tid_o, rsp_data_o);
      end
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_tid", 64'(rsp_tid_o), 64'(e.tid));
        chk("rsp_data", rsp_data_o, e.data);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [63:0] d);
    mmio_wr_valid_i = 1'b1; mmio_addr_i = a; mmio_wdata_i = d;
    step(1);
    mmio_wr_valid_i = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, input logic [8:0] t);
    mmio_rd_valid_i = 1'b1; mmio_addr_i = a; mmio_tid_i = t;
    step(1);
    mmio_rd_valid_i = 1'b0;
  endtask

  initial begin
    // Reset values
    step(3);
    chk("rst_fwd_wr", 64'(fwd_wr_valid_o), 64'd0);
    chk("rst_fwd_rd", 64'(fwd_rd_valid_o), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    chk("rst_almfull", 64'(sub_rsp_almfull_o), 64'd0);
    chk("rst_offsets", 64'(offset_flat_o != '0), 64'd0);
    chk("rst_en", 64'(sub_afu_en_o), 64'hFF);
    chk("rst_afu_reset", 64'(sub_afu_reset_o), 64'd0);
    reset = 1'b0;
    step(1);

    // OFFSET[3] write then read with exact response latency
    wr(16'h0016, 64'h1234);
    chk("offset3_flat", offset_flat_o[255:192], 64'h1234);
    sb.push_back({9'd5, 64'h1234});
    rd(16'h0016, 9'd5);
    chk("rd_lat_t1", 64'(rsp_valid_o), 64'd0);
    step(1);
    chk("rd_lat_t2", 64'(rsp_valid_o), 64'd1);
    step(1);
    chk("rd_one_cycle", 64'(rsp_valid_o), 64'd0);

    // Constant registers and enable
    sb.push_back({9'd1, DFH});           rd(16'h0000, 9'd1);
    sb.push_back({9'd2, ID_LO});         rd(16'h0002, 9'd2);
    sb.push_back({9'd3, ID_HI});         rd(16'h0004, 9'd3);
    sb.push_back({9'd4, 64'd8});         rd(16'h0008, 9'd4);
    wr(16'h000A, 64'h5A);
    chk("en_write", 64'(sub_afu_en_o), 64'h5A);
    sb.push_back({9'd6, 64'h5A});        rd(16'h000A, 9'd6);
    step(3);

    // Reset pulses: 0x05 at T, rewrite 0x01 at T+8
    wr(16'h0006, 64'h05);
    for (int k = 1; k <= 26; k++) begin
      logic [7:0] e;
      e = 8'({(k <= 16), 1'b0, (k <= 24)});
      chk($sformatf("afu_reset_k%0d", k), 64'(sub_afu_reset_o), 64'(e));
      if (k == 8) begin
        mmio_wr_valid_i = 1'b1; mmio_addr_i = 16'h0006; mmio_wdata_i = 64'h01;
      end else begin
        mmio_wr_valid_i = 1'b0;
      end
      step(1);
    end
    wr(16'h0006, 64'hFF00);
    chk("afu_reset_high_bits", 64'(sub_afu_reset_o), 64'd0);

    // Forwarding and unmapped words
    rd(16'h0400, 9'd9);
    chk("fwd_rd_valid", 64'(fwd_rd_valid_o), 64'd1);
    chk("fwd_rd_addr", 64'(fwd_addr_o), 64'h400);
    chk("fwd_rd_tid", 64'(fwd_tid_o), 64'd9);
    wr(16'h0802, 64'hCAFE);
    chk("fwd_wr_valid", 64'(fwd_wr_valid_o), 64'd1);
    chk("fwd_wr_data", fwd_wdata_o, 64'hCAFE);
    chk("fwd_rd_clear", 64'(fwd_rd_valid_o), 64'd0);
    step(1);
    chk("fwd_wr_clear", 64'(fwd_wr_valid_o), 64'd0);
    sb.push_back({9'd10, ONES});         rd(16'h03F0, 9'd10);
    sb.push_back({9'd11, ONES});         rd(16'h0020, 9'd11);

    // Scratch register
    wr(16'h000E, 64'hAA);
`ifdef VAI_CTL_SCRATCH_EN
    sb.push_back({9'd12, 64'hAA});
`else
    sb.push_back({9'd12, ONES});
`endif
    rd(16'h000E, 9'd12);
    step(3);

    // Control response and sub response in the same cycle
    sb.push_back({9'd13, DFH});
    sb.push_back({9'h1AB, 64'hDEAD_BEEF_0123_4567});
    sub_rsp_valid_i = 1'b1; sub_rsp_tid_i = 9'h1AB; sub_rsp_data_i = 64'hDEAD_BEEF_0123_4567;
    rd(16'h0000, 9'd13);
    sub_rsp_valid_i = 1'b0;
    step(4);
    chk("prio_drained", 64'(sb.size()), 64'd0);

    // FIFO fill with continuous control reads; 17th push is dropped
    for (int k = 0; k <= 16; k++) begin
      sb.push_back({9'(k), DFH});
      if (k < 16) sub_q.push_back({9'(9'h100 + k), 64'(k * 3 + 7)});
      sub_rsp_valid_i = 1'b1; sub_rsp_tid_i = 9'(9'h100 + k); sub_rsp_data_i = 64'(k * 3 + 7);
      rd(16'h0000, 9'(k));
      chk($sformatf("almfull_k%0d", k), 64'(sub_rsp_almfull_o), 64'(k >= 13));
    end
    sub_rsp_valid_i = 1'b0;
    while (sub_q.size() != 0) sb.push_back(sub_q.pop_front());
    step(25);
    chk("fill_drained", 64'(sb.size()), 64'd0);
    chk("almfull_after", 64'(sub_rsp_almfull_o), 64'd0);
    sb.push_back({9'd20, 64'd1});        rd(16'h000C, 9'd20);
    sb.push_back({9'd21, 64'd0});        rd(16'h000C, 9'd21);
    step(3);

    // Reset mid-operation discards in-flight responses and flushes the FIFO
    sub_rsp_valid_i = 1'b1; sub_rsp_tid_i = 9'h55; sub_rsp_data_i = 64'h77;
    rd(16'h0000, 9'd30);
    sub_rsp_valid_i = 1'b0;
    reset = 1'b1;
    step(1);
    chk("midrst_rsp", 64'(rsp_valid_o), 64'd0);
    chk("midrst_en", 64'(sub_afu_en_o), 64'hFF);
    chk("midrst_offsets", 64'(offset_flat_o != '0), 64'd0);
    reset = 1'b0;
    step(6);
    chk("sb_empty_end", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
